// File: rtl/uart_tx_queue_if.sv
// Producer-side and UART-side signals of uart_tx_queue in one bundle.
// The queue itself connects through the slave modport.
interface uart_tx_queue_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  overflow_clr;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_send;
  logic                  tx_data_ready;
  logic                  busy;

  modport slave (
    input  wr_data, wr_en, overflow_clr, tx_data_ready,
    output full, empty, count, overflow, tx_data, tx_send, busy
  );

  modport master (
    output wr_data, wr_en, overflow_clr, tx_data_ready,
    input  full, empty, count, overflow, tx_data, tx_send, busy
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus send sequencer for the UART transmitter: pops one byte per
// UART frame, paced on tx_data_ready, with a one-cycle tx_send pulse.
module uart_tx_queue #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_send_q;
  logic [TO_W-1:0]       timeout_q;

  logic full, empty, push, drop, pop;

  // Full/empty come from the registered count, so a pop never frees a slot
  // for a write in the same cycle.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign push  = bus.wr_en && !full;
  assign drop  = bus.wr_en && full;
  assign pop   = (state_q == S_IDLE) && !empty && bus.tx_data_ready;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block can infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop)                  overflow_d = 1'b1;
    else if (bus.overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is only ever assigned with <=, so every block
    // sees the pre-edge values regardless of evaluation order.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage has no reset; reset only rewinds the pointers and count,
  // which is enough to discard whatever is still queued.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      timeout_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_data_q <= mem_q[rd_ptr_q];
            tx_send_q <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          tx_send_q <= 1'b0;
          timeout_q <= '0;
          state_q   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A UART that never signals busy is treated as having taken the byte.
          if (!bus.tx_data_ready)      state_q   <= S_WAIT_DONE;
          else if (timeout_q == TO_LAST) state_q <= S_IDLE;
          else                         timeout_q <= timeout_q + TO_W'(1);
        end
        S_WAIT_DONE: begin
          if (bus.tx_data_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_send  = tx_send_q;
  assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a cycle-based UART ready model and a
// scoreboard of expected bytes, plus a table-driven overflow sequence.
module tb_uart_tx_queue;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int TO    = 16;

  typedef enum int {M_HOLD, M_STUCK, M_NORMAL} model_e;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr;
    logic       accept;
    logic [3:0] exp_count;
    logic       exp_full;
    logic       exp_overflow;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BUSY_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb[$];
  model_e     mode;
  int         fall_cnt, rise_cnt, rise_delay;
  int         cycle, pulses, last_pulse_cycle, pulse_gap;
  logic       busy_prev, send_prev;
  logic [7:0] data_prev;
  vec_t       vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_mode(input model_e m, input int rd);
    mode       = m;
    rise_delay = rd;
    fall_cnt   = 0;
    rise_cnt   = 0;
    bus.tx_data_ready = (m != M_HOLD);
  endtask

  // One clock: sample outputs 1 time unit after the edge, score any send
  // pulse, then let the UART model update tx_data_ready.
  task automatic tick();
    logic ready_before;
    ready_before = bus.tx_data_ready;
    @(posedge clk);
    #1;
    cycle++;
    if (bus.tx_send) begin
      pulses++;
      pulse_gap        = cycle - last_pulse_cycle;
      last_pulse_cycle = cycle;
      check("pop_while_ready", 32'(ready_before), 1);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: tx_data=0x%02h sent, nothing expected", bus.tx_data);
      end else begin
        check("tx_data_order", 32'(bus.tx_data), 32'(sb.pop_front()));
      end
    end
    if (send_prev) check("send_one_cycle", 32'(bus.tx_send), 0);
    if (busy_prev && bus.busy) check("tx_data_stable", 32'(bus.tx_data), 32'(data_prev));
    busy_prev = bus.busy;
    send_prev = bus.tx_send;
    data_prev = bus.tx_data;
    case (mode)
      M_HOLD:  bus.tx_data_ready = 1'b0;
      M_STUCK: bus.tx_data_ready = 1'b1;
      default: begin
        if (bus.tx_send) begin
          fall_cnt = 2;
        end else if (fall_cnt > 0) begin
          fall_cnt--;
          if (fall_cnt == 0) begin
            bus.tx_data_ready = 1'b0;
            rise_cnt = rise_delay;
          end
        end else if (rise_cnt > 0) begin
          rise_cnt--;
          if (rise_cnt == 0) bus.tx_data_ready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic write_byte(input logic [7:0] b, input logic accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (accept) sb.push_back(b);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((bus.busy || !bus.empty || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'({bus.busy, bus.empty, sb.size() == 0}), 32'b011);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int n;

    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.overflow_clr = 1'b0;
    bus.tx_data_ready = 1'b1;
    mode = M_NORMAL;
    rise_delay = 20;
    fall_cnt = 0;
    rise_cnt = 0;
    cycle = 0;
    pulses = 0;
    last_pulse_cycle = 0;
    pulse_gap = 0;
    busy_prev = 1'b0;
    send_prev = 1'b0;
    data_prev = '0;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_tx_send", 32'(bus.tx_send), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);

    // Single byte with the full-length UART frame model
    set_mode(M_NORMAL, 20);
    p0 = pulses;
    write_byte(8'h41, 1'b1);
    check("t1_count_after_write", 32'(bus.count), 1);
    check("t1_no_send_yet", 32'(bus.tx_send), 0);
    tick();
    check("t1_send_pulse", 32'(bus.tx_send), 1);
    check("t1_count_after_pop", 32'(bus.count), 0);
    check("t1_busy", 32'(bus.busy), 1);
    wait_drain(100, "t1_drain");
    check("t1_ready_at_idle", 32'(bus.tx_data_ready), 1);
    check("t1_pulses", 32'(pulses - p0), 1);

    // Ordering and pointer wrap: 12 bytes at a pace that never fills
    set_mode(M_NORMAL, 4);
    p0 = pulses;
    for (int i = 0; i < 12; i++) begin
      write_byte(8'(8'h30 + i), 1'b1);
      repeat (9) tick();
    end
    wait_drain(100, "t2_drain");
    check("t2_pulses", 32'(pulses - p0), 12);
    check("t2_overflow", 32'(bus.overflow), 0);

    // Overflow table: UART held busy, 10 writes, then overflow_clr cases
    for (int i = 0; i < 10; i++)
      vecs[i] = '{1'b1, 8'(8'h60 + i), 1'b0, 1'(i < 8),
                  4'((i < 8) ? i + 1 : 8), 1'(i >= 7), 1'(i >= 8)};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'h6A, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0};
    set_mode(M_HOLD, 0);
    p0 = pulses;
    for (int i = 0; i < 13; i++) begin
      bus.wr_en        = vecs[i].wr_en;
      bus.wr_data      = vecs[i].wr_data;
      bus.overflow_clr = vecs[i].clr;
      if (vecs[i].accept) sb.push_back(vecs[i].wr_data);
      tick();
      check($sformatf("t3_count_%0d", i), 32'(bus.count), 32'(vecs[i].exp_count));
      check($sformatf("t3_full_%0d", i), 32'(bus.full), 32'(vecs[i].exp_full));
      check($sformatf("t3_overflow_%0d", i), 32'(bus.overflow), 32'(vecs[i].exp_overflow));
    end
    bus.wr_en = 1'b0;
    bus.overflow_clr = 1'b0;
    set_mode(M_NORMAL, 4);
    wait_drain(200, "t3_drain");
    check("t3_pulses", 32'(pulses - p0), 8);

    // Timeout: UART never drops ready; SEND + 16 WAIT_BUSY + IDLE between pops
    set_mode(M_STUCK, 0);
    p0 = pulses;
    write_byte(8'h51, 1'b1);
    write_byte(8'h52, 1'b1);
    wait_drain(100, "t4_drain");
    check("t4_pulses", 32'(pulses - p0), 2);
    check("t4_pulse_gap", 32'(pulse_gap), 18);

    // Simultaneous push and pop
    set_mode(M_HOLD, 0);
    p0 = pulses;
    write_byte(8'h90, 1'b1);
    write_byte(8'h91, 1'b1);
    write_byte(8'h92, 1'b1);
    check("t5_count3", 32'(bus.count), 3);
    set_mode(M_NORMAL, 4);
    write_byte(8'h93, 1'b1);
    check("t5_push_pop_count", 32'(bus.count), 3);
    check("t5_push_pop_send", 32'(bus.tx_send), 1);
    wait_drain(200, "t5_drain_a");
    set_mode(M_HOLD, 0);
    for (int i = 0; i < 8; i++) write_byte(8'(8'hA0 + i), 1'b1);
    check("t5_full", 32'(bus.full), 1);
    check("t5_overflow_before", 32'(bus.overflow), 0);
    set_mode(M_NORMAL, 4);
    write_byte(8'hEE, 1'b0);
    check("t5_full_pop_count", 32'(bus.count), 7);
    check("t5_full_pop_overflow", 32'(bus.overflow), 1);
    check("t5_full_pop_send", 32'(bus.tx_send), 1);
    wait_drain(300, "t5_drain_b");
    check("t5_pulses", 32'(pulses - p0), 12);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    check("t5_overflow_clr", 32'(bus.overflow), 0);

    // Reset during WAIT_DONE with 4 bytes still queued
    set_mode(M_NORMAL, 20);
    for (int i = 0; i < 5; i++) write_byte(8'(8'hC0 + i), 1'b1);
    n = 0;
    while (bus.tx_data_ready && n < 50) begin
      tick();
      n++;
    end
    check("t6_ready_fell", 32'(bus.tx_data_ready), 0);
    tick();
    tick();
    check("t6_count_before", 32'(bus.count), 4);
    check("t6_busy_before", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    check("t6_empty", 32'(bus.empty), 1);
    check("t6_count", 32'(bus.count), 0);
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_tx_send", 32'(bus.tx_send), 0);
    check("t6_tx_data", 32'(bus.tx_data), 0);
    sb.delete();
    rst = 1'b0;
    set_mode(M_NORMAL, 20);
    p0 = pulses;
    repeat (30) tick();
    check("t6_no_pulse_after_rst", 32'(pulses - p0), 0);
    write_byte(8'h7E, 1'b1);
    wait_drain(100, "t6_drain");
    check("t6_pulses", 32'(pulses - p0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
